// File: rtl/pong_game_ctrl.sv
// Match and score controller for pong: tracks scores, sequences serves after
// a tick-counted delay and gates ball motion between points.
module pong_game_ctrl #(
    parameter int unsigned WIN_SCORE   = 10,
    parameter int unsigned SERVE_DELAY = 32
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tick,
    input  logic       start,
    input  logic       miss_p1,
    input  logic       miss_p2,
    output logic [1:0] state,
    output logic [3:0] p1_score,
    output logic [3:0] p2_score,
    output logic       ball_en,
    output logic       serve,
    output logic       serve_dir,
    output logic       p1_win,
    output logic       p2_win
);

    localparam int unsigned ST_W    = 2;
    localparam int unsigned SCORE_W = 4;
    localparam int unsigned CNT_W   = 8;

    localparam logic [ST_W-1:0] QI      = 2'b00;
    localparam logic [ST_W-1:0] QGAME_1 = 2'b01;
    localparam logic [ST_W-1:0] QGAME_2 = 2'b10;
    localparam logic [ST_W-1:0] QDONE   = 2'b11;

    localparam logic [SCORE_W-1:0] WIN_VAL   = SCORE_W'(WIN_SCORE);
    localparam logic [CNT_W-1:0]   DELAY_VAL = CNT_W'(SERVE_DELAY);
    localparam logic [CNT_W-1:0]   CNT_ONE   = CNT_W'(1);

    logic [ST_W-1:0]    r_state;
    logic [SCORE_W-1:0] r_p1_score;
    logic [SCORE_W-1:0] r_p2_score;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_ball_en;
    logic               r_serve;
    logic               r_serve_dir;
    logic               r_p1_win;
    logic               r_p2_win;

    logic [ST_W-1:0]    w_state_nxt;
    logic [SCORE_W-1:0] w_p1_score_nxt;
    logic [SCORE_W-1:0] w_p2_score_nxt;
    logic [CNT_W-1:0]   w_cnt_nxt;
    logic               w_ball_en_nxt;
    logic               w_serve_nxt;
    logic               w_serve_dir_nxt;
    logic               w_p1_win_nxt;
    logic               w_p2_win_nxt;

    logic [SCORE_W-1:0] w_p1_inc;
    logic [SCORE_W-1:0] w_p2_inc;
    logic               w_cnt_dec;

    assign w_p1_inc  = r_p1_score + SCORE_W'(1);
    assign w_p2_inc  = r_p2_score + SCORE_W'(1);
    assign w_cnt_dec = tick && !r_ball_en && (r_cnt != '0);

    // Next-state and next-output decode; register defaults hold their value.
    always_comb begin
        w_state_nxt     = r_state;
        w_p1_score_nxt  = r_p1_score;
        w_p2_score_nxt  = r_p2_score;
        w_cnt_nxt       = w_cnt_dec ? (r_cnt - CNT_ONE) : r_cnt;
        w_ball_en_nxt   = r_ball_en;
        w_serve_nxt     = 1'b0;
        w_serve_dir_nxt = r_serve_dir;
        w_p1_win_nxt    = r_p1_win;
        w_p2_win_nxt    = r_p2_win;

        case (r_state)
            QI: begin
                w_ball_en_nxt = 1'b0;
                if (start) begin
                    w_state_nxt    = QGAME_1;
                    w_p1_score_nxt = '0;
                    w_p2_score_nxt = '0;
                    w_cnt_nxt      = DELAY_VAL;
                    w_p1_win_nxt   = 1'b0;
                    w_p2_win_nxt   = 1'b0;
                end
            end

            QGAME_1, QGAME_2: begin
                if (!start) begin
                    w_state_nxt   = QI;
                    w_ball_en_nxt = 1'b0;
                end else if (r_ball_en) begin
                    // Misses only count while the ball is live.
                    if (miss_p1 && miss_p2) begin
                        w_ball_en_nxt = 1'b0;
                        w_cnt_nxt     = DELAY_VAL;
                    end else if (miss_p1) begin
                        w_ball_en_nxt  = 1'b0;
                        w_p2_score_nxt = w_p2_inc;
                        if (w_p2_inc == WIN_VAL) begin
                            w_state_nxt  = QDONE;
                            w_p2_win_nxt = 1'b1;
                        end else begin
                            w_state_nxt = QGAME_1;
                            w_cnt_nxt   = DELAY_VAL;
                        end
                    end else if (miss_p2) begin
                        w_ball_en_nxt  = 1'b0;
                        w_p1_score_nxt = w_p1_inc;
                        if (w_p1_inc == WIN_VAL) begin
                            w_state_nxt  = QDONE;
                            w_p1_win_nxt = 1'b1;
                        end else begin
                            w_state_nxt = QGAME_2;
                            w_cnt_nxt   = DELAY_VAL;
                        end
                    end
                end else if (tick && (r_cnt == CNT_ONE)) begin
                    w_cnt_nxt       = '0;
                    w_serve_nxt     = 1'b1;
                    w_ball_en_nxt   = 1'b1;
                    w_serve_dir_nxt = (r_state == QGAME_2);
                end
            end

            QDONE: begin
                w_ball_en_nxt = 1'b0;
                if (!start) begin
                    w_state_nxt = QI;
                end
            end

            default: begin
                w_state_nxt   = QI;
                w_ball_en_nxt = 1'b0;
            end
        endcase
    end

    // Synchronous reset overrides every other input.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= QI;
            r_p1_score  <= '0;
            r_p2_score  <= '0;
            r_cnt       <= '0;
            r_ball_en   <= 1'b0;
            r_serve     <= 1'b0;
            r_serve_dir <= 1'b0;
            r_p1_win    <= 1'b0;
            r_p2_win    <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_p1_score  <= w_p1_score_nxt;
            r_p2_score  <= w_p2_score_nxt;
            r_cnt       <= w_cnt_nxt;
            r_ball_en   <= w_ball_en_nxt;
            r_serve     <= w_serve_nxt;
            r_serve_dir <= w_serve_dir_nxt;
            r_p1_win    <= w_p1_win_nxt;
            r_p2_win    <= w_p2_win_nxt;
        end
    end

    assign state     = r_state;
    assign p1_score  = r_p1_score;
    assign p2_score  = r_p2_score;
    assign ball_en   = r_ball_en;
    assign serve     = r_serve;
    assign serve_dir = r_serve_dir;
    assign p1_win    = r_p1_win;
    assign p2_win    = r_p2_win;

endmodule

// File: tb/tb_pong_game_ctrl.sv
// Scenario bench for pong_game_ctrl: expected output snapshots are queued as
// stimulus is applied and compared once the corresponding edge has happened.
module tb_pong_game_ctrl;

    logic       clk = 1'b0;
    logic       reset, tick, start, miss_p1, miss_p2;
    logic [1:0] state;
    logic [3:0] p1_score, p2_score;
    logic       ball_en, serve, serve_dir, p1_win, p2_win;

    int total = 0;
    int bad   = 0;
    int serve_cnt = 0;

    typedef struct packed {
        logic [1:0] st;
        logic [3:0] p1;
        logic [3:0] p2;
        logic       be;
        logic       sv;
        logic       sd;
        logic       w1;
        logic       w2;
    } snap_t;

    snap_t exp_q[$];
    snap_t exp_s, obs_s;

    pong_game_ctrl #(.WIN_SCORE(10), .SERVE_DELAY(4)) dut (
        .clk(clk), .reset(reset), .tick(tick), .start(start),
        .miss_p1(miss_p1), .miss_p2(miss_p2),
        .state(state), .p1_score(p1_score), .p2_score(p2_score),
        .ball_en(ball_en), .serve(serve), .serve_dir(serve_dir),
        .p1_win(p1_win), .p2_win(p2_win)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (serve === 1'b1) serve_cnt++;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    function automatic snap_t snap();
        snap_t s;
        s.st = state; s.p1 = p1_score; s.p2 = p2_score; s.be = ball_en;
        s.sv = serve; s.sd = serve_dir; s.w1 = p1_win; s.w2 = p2_win;
        return s;
    endfunction

    function automatic snap_t mk(input logic [1:0] st, input int p1, input int p2,
                                 input logic be, input logic sv, input logic sd,
                                 input logic w1, input logic w2);
        snap_t s;
        s.st = st; s.p1 = 4'(p1); s.p2 = 4'(p2); s.be = be;
        s.sv = sv; s.sd = sd; s.w1 = w1; s.w2 = w2;
        return s;
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Four ticks spaced 8 clocks apart; returns just after the 4th tick edge.
    task automatic do_serve();
        for (int k = 0; k < 4; k++) begin
            tick = 1'b0;
            repeat (7) cyc();
            tick = 1'b1;
            cyc();
            tick = 1'b0;
        end
    endtask

    task automatic play_point(input bit p1_misses);
        do_serve();
        cyc();
        if (p1_misses) miss_p1 = 1'b1; else miss_p2 = 1'b1;
        cyc();
        miss_p1 = 1'b0;
        miss_p2 = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b1; tick = 1'b1; miss_p1 = 1'b1; miss_p2 = 1'b1;
        exp_q.push_back(mk(2'b00, 0, 0, 0, 0, 0, 0, 0));
        exp_q.push_back(mk(2'b00, 0, 0, 0, 0, 0, 0, 0));
        for (int i = 0; i < 2; i++) begin
            cyc();
            exp_s = exp_q.pop_front(); obs_s = snap(); total++;
            if (obs_s !== exp_s) begin
                bad++;
                $display("FAIL reset[%0d]: got=%b want=%b", i, obs_s, exp_s);
            end
        end
        reset = 1'b0; start = 1'b0; tick = 1'b0; miss_p1 = 1'b0; miss_p2 = 1'b0;
        cyc();
        total++;
        if (serve_cnt !== 0) begin
            bad++;
            $display("FAIL reset_serve: serve pulses=%0d want=0", serve_cnt);
        end
    endtask

    task automatic test_first_serve();
        int s0;
        start = 1'b1; tick = 1'b1;
        exp_q.push_back(mk(2'b01, 0, 0, 0, 0, 0, 0, 0));
        cyc();
        tick = 1'b0;
        exp_s = exp_q.pop_front(); obs_s = snap(); total++;
        if (obs_s !== exp_s) begin
            bad++; $display("FAIL start_entry: got=%b want=%b", obs_s, exp_s);
        end
        s0 = serve_cnt;
        exp_q.push_back(mk(2'b01, 0, 0, 1, 1, 0, 0, 0));
        do_serve();
        exp_s = exp_q.pop_front(); obs_s = snap(); total++;
        if (obs_s !== exp_s) begin
            bad++; $display("FAIL first_serve: got=%b want=%b", obs_s, exp_s);
        end
        total++;
        if (serve_cnt !== s0) begin
            bad++; $display("FAIL early_serve: pulses=%0d want=%0d", serve_cnt - s0, 0);
        end
        exp_q.push_back(mk(2'b01, 0, 0, 1, 0, 0, 0, 0));
        cyc();
        exp_s = exp_q.pop_front(); obs_s = snap(); total++;
        if (obs_s !== exp_s) begin
            bad++; $display("FAIL serve_width: got=%b want=%b", obs_s, exp_s);
        end
        total++;
        if (serve_cnt !== s0 + 1) begin
            bad++; $display("FAIL serve_count: pulses=%0d want=1", serve_cnt - s0);
        end
    endtask

    task automatic test_point_p2_miss();
        miss_p2 = 1'b1;
        exp_q.push_back(mk(2'b10, 1, 0, 0, 0, 0, 0, 0));
        cyc();
        miss_p2 = 1'b0;
        exp_s = exp_q.pop_front(); obs_s = snap(); total++;
        if (obs_s !== exp_s) begin
            bad++; $display("FAIL p2_miss_point: got=%b want=%b", obs_s, exp_s);
        end
        miss_p1 = 1'b1;
        exp_q.push_back(mk(2'b10, 1, 0, 0, 0, 0, 0, 0));
        cyc();
        miss_p1 = 1'b0;
        exp_s = exp_q.pop_front(); obs_s = snap(); total++;
        if (obs_s !== exp_s) begin
            bad++; $display("FAIL miss_while_idle: got=%b want=%b", obs_s, exp_s);
        end
        exp_q.push_back(mk(2'b10, 1, 0, 1, 1, 1, 0, 0));
        do_serve();
        exp_s = exp_q.pop_front(); obs_s = snap(); total++;
        if (obs_s !== exp_s) begin
            bad++; $display("FAIL p2_serve: got=%b want=%b", obs_s, exp_s);
        end
        cyc();
    endtask

    task automatic test_win_p2();
        for (int i = 1; i <= 10; i++) begin
            miss_p1 = 1'b1;
            exp_q.push_back(mk((i == 10) ? 2'b11 : 2'b01, 1, i, 0, 0,
                               (i == 1) ? 1'b1 : 1'b0, 0, (i == 10) ? 1'b1 : 1'b0));
            cyc();
            miss_p1 = 1'b0;
            exp_s = exp_q.pop_front(); obs_s = snap(); total++;
            if (obs_s !== exp_s) begin
                bad++; $display("FAIL win_point[%0d]: got=%b want=%b", i, obs_s, exp_s);
            end
            if (i < 10) begin
                exp_q.push_back(mk(2'b01, 1, i, 1, 1, 0, 0, 0));
                do_serve();
                exp_s = exp_q.pop_front(); obs_s = snap(); total++;
                if (obs_s !== exp_s) begin
                    bad++; $display("FAIL win_serve[%0d]: got=%b want=%b", i, obs_s, exp_s);
                end
                cyc();
            end
        end
        // QDONE ignores misses and ticks; win flag survives the drop to QI.
        miss_p1 = 1'b1; miss_p2 = 1'b1; tick = 1'b1;
        exp_q.push_back(mk(2'b11, 1, 10, 0, 0, 0, 0, 1));
        exp_q.push_back(mk(2'b11, 1, 10, 0, 0, 0, 0, 1));
        for (int i = 0; i < 2; i++) begin
            cyc();
            exp_s = exp_q.pop_front(); obs_s = snap(); total++;
            if (obs_s !== exp_s) begin
                bad++; $display("FAIL done_frozen[%0d]: got=%b want=%b", i, obs_s, exp_s);
            end
        end
        miss_p1 = 1'b0; miss_p2 = 1'b0; tick = 1'b0;
        start = 1'b0;
        exp_q.push_back(mk(2'b00, 1, 10, 0, 0, 0, 0, 1));
        cyc();
        exp_s = exp_q.pop_front(); obs_s = snap(); total++;
        if (obs_s !== exp_s) begin
            bad++; $display("FAIL done_to_idle: got=%b want=%b", obs_s, exp_s);
        end
        start = 1'b1;
        exp_q.push_back(mk(2'b01, 0, 0, 0, 0, 0, 0, 0));
        cyc();
        exp_s = exp_q.pop_front(); obs_s = snap(); total++;
        if (obs_s !== exp_s) begin
            bad++; $display("FAIL restart: got=%b want=%b", obs_s, exp_s);
        end
    endtask

    task automatic test_double_miss();
        int s0;
        for (int i = 0; i < 5; i++) play_point(1'b1);
        for (int i = 0; i < 3; i++) play_point(1'b0);
        exp_q.push_back(mk(2'b10, 3, 5, 0, 0, 1, 0, 0));
        exp_s = exp_q.pop_front(); obs_s = snap(); total++;
        if (obs_s !== exp_s) begin
            bad++; $display("FAIL rally_setup: got=%b want=%b", obs_s, exp_s);
        end
        do_serve();
        cyc();
        miss_p1 = 1'b1; miss_p2 = 1'b1;
        exp_q.push_back(mk(2'b10, 3, 5, 0, 0, 1, 0, 0));
        cyc();
        miss_p1 = 1'b0; miss_p2 = 1'b0;
        exp_s = exp_q.pop_front(); obs_s = snap(); total++;
        if (obs_s !== exp_s) begin
            bad++; $display("FAIL double_miss: got=%b want=%b", obs_s, exp_s);
        end
        s0 = serve_cnt;
        exp_q.push_back(mk(2'b10, 3, 5, 1, 1, 1, 0, 0));
        do_serve();
        exp_s = exp_q.pop_front(); obs_s = snap(); total++;
        if (obs_s !== exp_s) begin
            bad++; $display("FAIL replay_serve: got=%b want=%b", obs_s, exp_s);
        end
        total++;
        if (serve_cnt !== s0) begin
            bad++; $display("FAIL replay_early: pulses=%0d want=0", serve_cnt - s0);
        end
        cyc();
    endtask

    task automatic test_abort();
        start = 1'b0;
        exp_q.push_back(mk(2'b00, 3, 5, 0, 0, 1, 0, 0));
        cyc();
        exp_s = exp_q.pop_front(); obs_s = snap(); total++;
        if (obs_s !== exp_s) begin
            bad++; $display("FAIL abort_start: got=%b want=%b", obs_s, exp_s);
        end
        start = 1'b1;
        cyc();
        for (int i = 0; i < 2; i++) play_point(1'b1);
        for (int i = 0; i < 7; i++) play_point(1'b0);
        do_serve();
        exp_q.push_back(mk(2'b10, 7, 2, 1, 0, 1, 0, 0));
        cyc();
        exp_s = exp_q.pop_front(); obs_s = snap(); total++;
        if (obs_s !== exp_s) begin
            bad++; $display("FAIL pre_reset: got=%b want=%b", obs_s, exp_s);
        end
        reset = 1'b1; miss_p2 = 1'b1;
        exp_q.push_back(mk(2'b00, 0, 0, 0, 0, 0, 0, 0));
        cyc();
        reset = 1'b0; miss_p2 = 1'b0; start = 1'b0;
        exp_s = exp_q.pop_front(); obs_s = snap(); total++;
        if (obs_s !== exp_s) begin
            bad++; $display("FAIL mid_reset: got=%b want=%b", obs_s, exp_s);
        end
        exp_q.push_back(mk(2'b00, 0, 0, 0, 0, 0, 0, 0));
        cyc();
        exp_s = exp_q.pop_front(); obs_s = snap(); total++;
        if (obs_s !== exp_s) begin
            bad++; $display("FAIL post_reset: got=%b want=%b", obs_s, exp_s);
        end
    endtask

    initial begin
        reset = 1'b0; tick = 1'b0; start = 1'b0; miss_p1 = 1'b0; miss_p2 = 1'b0;
        test_reset();
        test_first_serve();
        test_point_p2_miss();
        test_win_p2();
        test_double_miss();
        test_abort();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pong_game_ctrl.md
Name: pong_game_ctrl

Overview:
- Match/score controller for the pong game.
- Consumes miss events from the ball/paddle motion logic and the start switch.
- Produces game state, per-player scores, serve timing and ball enable.
- Outputs feed the motion logic (ball_en, serve, serve_dir) and the LED/seven-segment display logic (state, p1_score, p2_score, win flags).

Parameters:
- WIN_SCORE, 10, point total that ends the match (4-bit compare).
- SERVE_DELAY, 32, number of tick strobes between a point and the next serve (1..255).

Ports:
- clk  input  1  system clock (divided board clock)
- reset  input  1  synchronous, active-high reset
- tick  input  1  one-clk game-update strobe (motion update rate)
- start  input  1  start switch level (already synchronised)
- miss_p1  input  1  one-clk pulse: ball passed player 1 (left) paddle
- miss_p2  input  1  one-clk pulse: ball passed player 2 (right) paddle
- state  output  2  00 QI, 01 QGAME_1 (P1 serves), 10 QGAME_2 (P2 serves), 11 QDONE
- p1_score  output  4  player 1 points, 0..WIN_SCORE
- p2_score  output  4  player 2 points, 0..WIN_SCORE
- ball_en  output  1  ball motion allowed
- serve  output  1  one-clk pulse: motion logic reloads ball at server paddle
- serve_dir  output  1  0 = ball travels +X (P1 serve), 1 = -X (P2 serve)
- p1_win  output  1  high in QDONE when P1 reached WIN_SCORE
- p2_win  output  1  high in QDONE when P2 reached WIN_SCORE

Behaviour:
- Interface: one clock, clk; reset is synchronous and active-high, port reset. All registers update on posedge clk only.
- Reset values: state=QI, scores=0, ball_en=0, serve=0, serve_dir=0, p1_win=p2_win=0, delay counter=0. Reset overrides every other input in the same cycle and aborts any match in progress.
- Delay counter: 8-bit.
  - Loaded with SERVE_DELAY on entry to QGAME_1/QGAME_2 and after each non-final point.
  - Decrements only on clk where tick=1 and ball_en=0 and counter>0.
- Serve: on the clk where tick=1 and the counter is 1, in a QGAME state with ball_en=0:
  - counter goes to 0, serve pulses for exactly that one clk, ball_en goes to 1 on the same edge.
  - serve_dir = 0 in QGAME_1, 1 in QGAME_2.
- QI:
  - ball_en=0, scores held.
  - start=1 -> QGAME_1: scores cleared to 0, delay loaded, win flags cleared.
- QGAME_1 / QGAME_2:
  - start=0 -> QI next clk. ball_en=0, scores held; they clear on the next start.
  - Miss pulses are acted on only when ball_en=1. Misses while ball_en=0 are ignored.
  - miss_p1 alone -> p2_score+1, ball_en=0.
    - New p2_score==WIN_SCORE -> QDONE, p2_win=1.
    - Otherwise -> QGAME_1 (the loser, P1, serves), delay reloaded.
  - miss_p2 alone -> symmetric: p1_score+1; QDONE with p1_win=1, or QGAME_2.
  - miss_p1 and miss_p2 in the same clk: no score change, ball_en=0, same state, delay reloaded (replay serve).
  - The score increment and state change take effect on the same edge (1-clk latency from the miss pulse).
- QDONE:
  - ball_en=0, scores and the win flag frozen, miss inputs ignored.
  - start=0 -> QI; win flags held until the next QGAME entry.
- Scores never exceed WIN_SCORE; no wrap-around is possible.
- Serve and a miss cannot both be active in one clk, because misses are gated by the registered ball_en.
- start and tick both high on a QI->QGAME_1 clk: the counter loads SERVE_DELAY and does not decrement that clk.

Test Plan:
- reset=1 for 2 clks with start=1, miss pulses active -> state=00, scores 0/0, ball_en=0, serve never pulses.
- SERVE_DELAY=4; start=1, tick every 8 clks -> state=01 one clk later; serve a single 1-clk pulse on the 4th tick, same edge ball_en=1, serve_dir=0.
- After the serve, pulse miss_p2 -> next clk p1_score=1, state=10, ball_en=0; 4 ticks later serve pulses with serve_dir=1. Pulse miss_p1 while ball_en=0 -> no change.
- Alternate serve/miss_p1 until p2_score=10 -> state=11, p2_win=1, p1_win=0, ball_en=0. Further misses leave score 10. start=0 -> state=00; start=1 -> scores 0/0, p2_win=0, state=01.
- Simultaneous miss_p1 and miss_p2 with ball_en=1, state=10, scores 3/5 -> scores stay 3/5, state 10, ball_en=0, serve again after SERVE_DELAY ticks.
- Mid-rally start=0 -> state=00, ball_en=0 next clk. Mid-rally reset with scores 7/2 -> everything returns to reset values on the next edge.
